// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared state encoding and default parameters for the FIFO read-side stream adapter
package fifo_rd_pkg;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} rd_state_t;
    localparam int DSIZE_DEF = 8;
    localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: pops a show-ahead async FIFO read port into a registered valid/ready stream via a 2-entry skid buffer
//   rclk    in   read-domain clock
//   rrst    in   asynchronous active-low reset
//   rData   in   FIFO head word (valid when rEmpty=0)
//   rEmpty  in   FIFO empty flag
//   rinc    out  FIFO pop strobe
//   enable  in   allow pops; buffered words always drain
//   m_data  out  stream data
//   m_valid out  stream valid
//   m_ready in   stream ready
//   busy    out  a word is held in the buffer
//   pop_cnt out  total words popped, wrapping (only with FIFO_RD_CNT_EN defined)
module fifo_rd_stream_adapter
    import fifo_rd_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
`ifdef FIFO_RD_CNT_EN
    , parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [DSIZE-1:0] rData,
    input  logic             rEmpty,
    output logic             rinc,
    input  logic             enable,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
`ifdef FIFO_RD_CNT_EN
    output logic [CNT_W-1:0] pop_cnt,
`endif
    output logic             busy
);
    rd_state_t        r_state, w_nxt;
    logic [DSIZE-1:0] r_main, r_skid;
    logic             w_pop, w_fire, w_ld_main, w_ld_skid;
    // Pop depends only on registered state and FIFO/enable inputs, never on m_ready; held off during reset.
    assign w_pop     = rrst & enable & ~rEmpty & (r_state != FULL);
    assign w_fire    = m_valid & m_ready;
    assign w_ld_main = (w_pop & ((r_state == EMPTY) | w_fire)) | ((r_state == FULL) & w_fire);
    assign w_ld_skid = w_pop & ~w_fire & (r_state == ONE);
    assign rinc      = w_pop;
    assign m_valid   = (r_state != EMPTY);
    assign busy      = m_valid;
    assign m_data    = r_main;
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            EMPTY:   w_nxt = w_pop ? ONE : EMPTY;
            ONE:     w_nxt = (w_pop & ~w_fire) ? FULL : (~w_pop & w_fire) ? EMPTY : ONE;
            FULL:    w_nxt = w_fire ? ONE : FULL;
            default: w_nxt = EMPTY;
        endcase
    end
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) r_state <= EMPTY;
        else       r_state <= w_nxt;
    end
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_ld_main) r_main <= (r_state == FULL) ? r_skid : rData;
            if (w_ld_skid) r_skid <= rData;
        end
    end
`ifdef FIFO_RD_CNT_EN
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst)     pop_cnt <= '0;
        else if (rinc) pop_cnt <= pop_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb_fifo_rd_stream_adapter: directed self-checking bench with a simple show-ahead FIFO model feeding the adapter
module tb_fifo_rd_stream_adapter;
    localparam int CW = 4;
    logic       rclk = 0, rrst = 0, rinc, enable = 1, m_valid, m_ready = 0, busy, bubble = 0;
    logic [7:0] rData, m_data;
    logic       rEmpty;
`ifdef FIFO_RD_CNT_EN
    logic [CW-1:0] pop_cnt;
`endif
    logic [7:0] mem [0:31];
    int         rd_ptr = 0, wr_ptr = 0;
    int         checks = 0, errors = 0, npop;
    logic [7:0] t3 [0:3];
    logic [7:0] t4v [0:6];
    logic       t4r [0:6];

    fifo_rd_stream_adapter #(
        .DSIZE(8)
`ifdef FIFO_RD_CNT_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .rclk(rclk), .rrst(rrst), .rData(rData), .rEmpty(rEmpty), .rinc(rinc), .enable(enable),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
`ifdef FIFO_RD_CNT_EN
        .pop_cnt(pop_cnt),
`endif
        .busy(busy)
    );

    always #5 rclk = ~rclk;
    assign rData  = mem[rd_ptr[4:0]];
    assign rEmpty = (rd_ptr == wr_ptr) | bubble;
    always @(posedge rclk or negedge rrst) begin
        if (!rrst)     rd_ptr <= 0;
        else if (rinc) rd_ptr <= rd_ptr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[4:0]] = d;
        wr_ptr++;
    endtask

    task automatic tick;
        @(posedge rclk);
        #1;
    endtask

    initial begin
        // reset holds the pop strobe low even with data available and enable high
        push(8'hEE);
        #2;
        chk("rst_rinc", rinc, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", m_data, 0);
`ifdef FIFO_RD_CNT_EN
        chk("rst_cnt", pop_cnt, 0);
`endif
        wr_ptr = 0;
        tick;
        rrst = 1;
        // streaming 01..10 at full rate
        m_ready = 1;
        for (int i = 1; i <= 16; i++) push(8'(i));
        for (int k = 0; k <= 17; k++) begin
            #1;
            chk("t2_rinc", rinc, (k < 16) ? 1 : 0);
            chk("t2_valid", m_valid, (k > 0 && k < 17) ? 1 : 0);
            if (k > 0 && k < 17) chk("t2_data", m_data, k);
            tick;
        end
`ifdef FIFO_RD_CNT_EN
        chk("t2_cnt", pop_cnt, 16 % 16);
`endif
        // backpressure: two pops fill the buffer, A1 held, A3 popped after first fire
        m_ready = 0;
        push(8'hA1); push(8'hA2); push(8'hA3);
        #1; chk("t3_rinc0", rinc, 1); chk("t3_valid0", m_valid, 0); tick;
        #1; chk("t3_rinc1", rinc, 1); chk("t3_data1", m_data, 8'hA1); tick;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_hold_rinc", rinc, 0);
            chk("t3_hold_valid", m_valid, 1);
            chk("t3_hold_data", m_data, 8'hA1);
            chk("t3_hold_busy", busy, 1);
            tick;
        end
        m_ready = 1;
        t3[0] = 8'hA1; t3[1] = 8'hA2; t3[2] = 8'hA3;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_drain_data", m_data, t3[k]);
            chk("t3_drain_valid", m_valid, 1);
            chk("t3_drain_rinc", rinc, (k == 1) ? 1 : 0);
            tick;
        end
        #1; chk("t3_end_valid", m_valid, 0);
`ifdef FIFO_RD_CNT_EN
        chk("t3_cnt", pop_cnt, 19 % 16);
`endif
        // bubbles: rEmpty alternates each cycle
        push(8'h55); push(8'h66); push(8'h77);
        t4r[0] = 1; t4r[1] = 0; t4r[2] = 1; t4r[3] = 0; t4r[4] = 1; t4r[5] = 0; t4r[6] = 0;
        t4v[1] = 8'h55; t4v[3] = 8'h66; t4v[5] = 8'h77;
        for (int k = 0; k < 7; k++) begin
            bubble = k[0];
            #1;
            chk("t4_rinc", rinc, t4r[k]);
            chk("t4_valid", m_valid, k[0]);
            if (k[0]) chk("t4_data", m_data, t4v[k]);
            tick;
        end
        bubble = 0;
        // enable drop while full with words left in the FIFO
        m_ready = 0;
        push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4); push(8'hB5);
        tick; tick;
        enable = 0;
        m_ready = 1;
        #1; chk("t5_rinc0", rinc, 0); chk("t5_data0", m_data, 8'hB1); chk("t5_valid0", m_valid, 1); tick;
        #1; chk("t5_rinc1", rinc, 0); chk("t5_data1", m_data, 8'hB2); tick;
        #1;
        chk("t5_valid_end", m_valid, 0);
        chk("t5_busy_end", busy, 0);
        chk("t5_rinc_end", rinc, 0);
        chk("t5_left", wr_ptr - rd_ptr, 3);
`ifdef FIFO_RD_CNT_EN
        chk("t5_cnt", pop_cnt, 24 % 16);
`endif
        // mid-operation reset from FULL, then counter wrap
        enable = 1;
        m_ready = 0;
        tick; tick;
        #1; chk("t6_full_busy", busy, 1); chk("t6_full_data", m_data, 8'hB3);
        rrst = 0;
        #1;
        chk("t6_rst_valid", m_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rinc", rinc, 0);
        chk("t6_rst_data", m_data, 0);
`ifdef FIFO_RD_CNT_EN
        chk("t6_rst_cnt", pop_cnt, 0);
`endif
        wr_ptr = 0;
        tick;
        rrst = 1;
        m_ready = 1;
        for (int i = 0; i < 17; i++) push(8'(8'h80 + i));
        npop = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (rinc) npop++;
            if (k == 17) chk("t6_last_data", m_data, 8'h90);
            tick;
        end
        chk("t6_pops", npop, 17);
        chk("t6_valid_end", m_valid, 0);
`ifdef FIFO_RD_CNT_EN
        chk("t6_wrap_cnt", pop_cnt, 17 % 16);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
